// File: rtl/elastic_context_multiplexer.sv
// Elastic N:1 multiplexer steered by a round-robin context table, with a 2-entry output buffer.
// Optional feature: define ELASTIC_MUX_STALL_COUNTER_EN to add the saturating stall_count output.
module elastic_context_multiplexer #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int INPUT_NUM   = 4,
  parameter  int CONTEXT_NUM = 8,
  localparam int CTX_W       = (CONTEXT_NUM > 1) ? $clog2(CONTEXT_NUM) : 1,
  localparam int IDX_W       = $clog2(INPUT_NUM)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [INPUT_NUM-1:0][DATA_WIDTH-1:0] data_input,
  input  logic [INPUT_NUM-1:0]                 valid_input,
  output logic [INPUT_NUM-1:0]                 stop_input,
  output logic [DATA_WIDTH-1:0]                data_output,
  output logic                                 valid_output,
  input  logic                                 stop_output,
  input  logic                                 config_we,
  input  logic [CTX_W-1:0]                     config_addr,
  input  logic [IDX_W-1:0]                     config_index,
  output logic [CTX_W-1:0]                     context_id,
  output logic                                 switch_context
`ifdef ELASTIC_MUX_STALL_COUNTER_EN
  ,
  output logic [31:0]                          stall_count
`endif
);

  localparam logic [IDX_W:0]   INPUT_LIMIT = (IDX_W + 1)'(INPUT_NUM);
  localparam logic [CTX_W-1:0] CTX_LAST    = CTX_W'(CONTEXT_NUM - 1);

  logic [IDX_W-1:0]      r_table [CONTEXT_NUM];
  logic [CTX_W-1:0]      r_ctx;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  logic [IDX_W-1:0]      w_sel;
  logic [INPUT_NUM-1:0]  w_stop;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_cfg_ok;
  logic [DATA_WIDTH-1:0] w_din;

  // Backpressure to the selected channel comes only from the registered count,
  // so there is no combinational path from stop_output to stop_input.
  always_comb begin
    w_sel    = r_table[r_ctx];
    w_full   = (r_count == 2'd2);
    w_stop   = '1;
    if (!reset) begin
      w_stop[w_sel] = w_full;
    end
    w_accept = valid_input[w_sel] & ~w_stop[w_sel];
    w_pop    = (r_count != 2'd0) & ~stop_output;
    w_din    = data_input[w_sel];
    w_cfg_ok = config_we && ({1'b0, config_index} < INPUT_LIMIT) && (config_addr <= CTX_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CONTEXT_NUM; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_cfg_ok) begin
      r_table[config_addr] <= config_index;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctx <= '0;
    end else if (w_accept) begin
      r_ctx <= (r_ctx == CTX_LAST) ? '0 : r_ctx + CTX_W'(1);
    end
  end

  // r_head is always the oldest token; r_tail only matters when two are held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= w_din;
          end else begin
            r_tail <= w_din;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          r_head <= w_din;
        end
        default: begin
        end
      endcase
    end
  end

  assign stop_input     = w_stop;
  assign data_output    = r_head;
  assign valid_output   = (r_count != 2'd0);
  assign context_id     = r_ctx;
  assign switch_context = w_accept;

`ifdef ELASTIC_MUX_STALL_COUNTER_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (valid_output && stop_output && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_elastic_context_multiplexer.sv
// Directed bench for elastic_context_multiplexer: vector table for round robin and
// backpressure, plus hand sequences for stall, reconfiguration race and mid-run reset.
module tb_elastic_context_multiplexer;

  logic              clk;
  logic              reset;
  logic [3:0][31:0]  data_input;
  logic [3:0]        valid_input;
  logic [3:0]        stop_input;
  logic [31:0]       data_output;
  logic              valid_output;
  logic              stop_output;
  logic              config_we;
  logic [2:0]        config_addr;
  logic [1:0]        config_index;
  logic [2:0]        context_id;
  logic              switch_context;
`ifdef ELASTIC_MUX_STALL_COUNTER_EN
  logic [31:0]       stall_count;
`endif

  elastic_context_multiplexer #(
    .DATA_WIDTH (32),
    .INPUT_NUM  (4),
    .CONTEXT_NUM(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_input    (data_input),
    .valid_input   (valid_input),
    .stop_input    (stop_input),
    .data_output   (data_output),
    .valid_output  (valid_output),
    .stop_output   (stop_output),
    .config_we     (config_we),
    .config_addr   (config_addr),
    .config_index  (config_index),
    .context_id    (context_id),
    .switch_context(switch_context)
`ifdef ELASTIC_MUX_STALL_COUNTER_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass;
  int n_total;

  typedef struct {
    logic [3:0]  vin;
    logic        sout;
    logic        exp_vout;
    logic [31:0] exp_dout;
    logic [3:0]  exp_sin;
    logic        exp_sw;
    logic [2:0]  exp_ctx;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [1:0] idx);
    config_we    = 1'b1;
    config_addr  = addr;
    config_index = idx;
    tick();
    config_we    = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] vin, input logic sout, input logic vout,
                              input logic [31:0] dout, input logic [3:0] sin,
                              input logic sw, input logic [2:0] ctx);
    vec_t v;
    v.vin = vin; v.sout = sout; v.exp_vout = vout; v.exp_dout = dout;
    v.exp_sin = sin; v.exp_sw = sw; v.exp_ctx = ctx;
    return v;
  endfunction

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int i = 0; i < 4; i++) data_input[i] = 32'hA0 + 32'(i);
    // Round robin over table {0,1,2,3,0,1,2,3}, then 5 stalled cycles, then drain.
    vecs[0]  = mk(4'hF, 0, 0, 32'h00, 4'hE, 1, 0);
    vecs[1]  = mk(4'hF, 0, 1, 32'hA0, 4'hD, 1, 1);
    vecs[2]  = mk(4'hF, 0, 1, 32'hA1, 4'hB, 1, 2);
    vecs[3]  = mk(4'hF, 0, 1, 32'hA2, 4'h7, 1, 3);
    vecs[4]  = mk(4'hF, 0, 1, 32'hA3, 4'hE, 1, 4);
    vecs[5]  = mk(4'hF, 0, 1, 32'hA0, 4'hD, 1, 5);
    vecs[6]  = mk(4'hF, 0, 1, 32'hA1, 4'hB, 1, 6);
    vecs[7]  = mk(4'hF, 0, 1, 32'hA2, 4'h7, 1, 7);
    vecs[8]  = mk(4'hF, 0, 1, 32'hA3, 4'hE, 1, 0);
    vecs[9]  = mk(4'hF, 1, 1, 32'hA0, 4'hD, 1, 1);
    vecs[10] = mk(4'hF, 1, 1, 32'hA0, 4'hF, 0, 2);
    vecs[11] = mk(4'hF, 1, 1, 32'hA0, 4'hF, 0, 2);
    vecs[12] = mk(4'hF, 1, 1, 32'hA0, 4'hF, 0, 2);
    vecs[13] = mk(4'hF, 1, 1, 32'hA0, 4'hF, 0, 2);
    vecs[14] = mk(4'hF, 0, 1, 32'hA0, 4'hF, 0, 2);
    vecs[15] = mk(4'hF, 0, 1, 32'hA1, 4'hB, 1, 2);
    vecs[16] = mk(4'hF, 0, 1, 32'hA2, 4'h7, 1, 3);
    vecs[17] = mk(4'hF, 0, 1, 32'hA3, 4'hE, 1, 4);
    vecs[18] = mk(4'h0, 0, 1, 32'hA0, 4'hD, 0, 5);
    vecs[19] = mk(4'h0, 0, 0, 32'h00, 4'hD, 0, 5);

    reset        = 1'b1;
    valid_input  = 4'hF;
    stop_output  = 1'b0;
    config_we    = 1'b0;
    config_addr  = '0;
    config_index = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst vout", 32'(valid_output), 32'd0);
    check("rst dout", data_output, 32'd0);
    check("rst ctx", 32'(context_id), 32'd0);
    check("rst sw", 32'(switch_context), 32'd0);
    check("rst sin", 32'(stop_input), 32'hF);
    valid_input = 4'h0;
    reset = 1'b0;
    #1;
    check("post-rst sin", 32'(stop_input), 32'hE);

    for (int a = 0; a < 8; a++) cfg_write(3'(a), 2'(a % 4));

    for (int k = 0; k < 20; k++) begin
      valid_input = vecs[k].vin;
      stop_output = vecs[k].sout;
      #1;
      check($sformatf("vec%0d vout", k), 32'(valid_output), 32'(vecs[k].exp_vout));
      if (vecs[k].exp_vout) check($sformatf("vec%0d dout", k), data_output, vecs[k].exp_dout);
      check($sformatf("vec%0d sin", k), 32'(stop_input), 32'(vecs[k].exp_sin));
      check($sformatf("vec%0d sw", k), 32'(switch_context), 32'(vecs[k].exp_sw));
      check($sformatf("vec%0d ctx", k), 32'(context_id), 32'(vecs[k].exp_ctx));
      tick();
    end

    // Non-selected stall: sel=2 while only input 1 is valid.
    cfg_write(3'd5, 2'd2);
    valid_input = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("nsel vout", 32'(valid_output), 32'd0);
      check("nsel sin", 32'(stop_input), 32'hB);
      check("nsel ctx", 32'(context_id), 32'd5);
      check("nsel sw", 32'(switch_context), 32'd0);
      tick();
    end

    // Reconfiguration race: table[5] rewritten to 3 in the cycle input 0 is accepted.
    valid_input = 4'h0;
    cfg_write(3'd5, 2'd0);
    config_we    = 1'b1;
    config_addr  = 3'd5;
    config_index = 2'd3;
    valid_input  = 4'b0001;
    #1;
    check("race sw", 32'(switch_context), 32'd1);
    check("race sin", 32'(stop_input), 32'hE);
    tick();
    config_we   = 1'b0;
    valid_input = 4'h0;
    #1;
    check("race dout", data_output, 32'hA0);
    check("race ctx", 32'(context_id), 32'd6);
    tick();
    valid_input = 4'hF;
    repeat (7) tick();
    valid_input = 4'b1000;
    #1;
    check("race2 ctx", 32'(context_id), 32'd5);
    check("race2 sin", 32'(stop_input), 32'h7);
    check("race2 sw", 32'(switch_context), 32'd1);
    tick();
    valid_input = 4'h0;
    #1;
    check("race2 vout", 32'(valid_output), 32'd1);
    check("race2 dout", data_output, 32'hA3);
    tick();

    // Reset while the buffer is full.
    valid_input = 4'hF;
    stop_output = 1'b1;
    repeat (3) tick();
    check("full sin", 32'(stop_input), 32'hF);
    check("full vout", 32'(valid_output), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst vout", 32'(valid_output), 32'd0);
    check("arst ctx", 32'(context_id), 32'd0);
    check("arst sin", 32'(stop_input), 32'hF);
    check("arst sw", 32'(switch_context), 32'd0);
    #1;
    reset = 1'b0;
    stop_output = 1'b0;
    #1;
    check("after rst vout", 32'(valid_output), 32'd0);
    check("after rst sin", 32'(stop_input), 32'hE);
    check("after rst sw", 32'(switch_context), 32'd1);
    tick();
    valid_input = 4'h0;
    #1;
    check("after rst dout", data_output, 32'hA0);
    check("after rst vout1", 32'(valid_output), 32'd1);
    check("after rst ctx", 32'(context_id), 32'd1);
    tick();
    #1;
    check("after rst drained", 32'(valid_output), 32'd0);

`ifdef ELASTIC_MUX_STALL_COUNTER_EN
    #1;
    reset = 1'b1;
    #1;
    check("stall rst", stall_count, 32'd0);
    reset = 1'b0;
    tick();
    valid_input = 4'b0001;
    tick();
    valid_input = 4'h0;
    stop_output = 1'b1;
    repeat (10) tick();
    #1;
    check("stall 10", stall_count, 32'd10);
    force dut.r_stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_count;
    repeat (3) tick();
    #1;
    check("stall sat", stall_count, 32'hFFFF_FFFF);
    stop_output = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
